// File: rtl/serial_reader_pkg.sv
// Word format and receive-FSM encodings shared by both ends of the serial link.
package serial_reader_pkg;

  localparam int RW_WIDTH  = 64;
  localparam int RW_CWIDTH = 6;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_SHIFT = 1'b1
  } rd_state_e;

endpackage

// File: rtl/serial_reader_hold_reg.sv
// One-deep holding register between the shifter and the consumer: accepts,
// drops (flagging a sticky overrun) or releases completed words.
module rx_hold_reg
  import serial_reader_pkg::*;
#(
  parameter int width = RW_WIDTH
) (
  input  logic             sclk,
  input  logic             reset_n,
  input  logic [width-1:0] word,
  input  logic             word_done,
  input  logic             data_ack,
  output logic [width-1:0] data_out,
  output logic             data_valid,
  output logic             overrun
);

  // An ack on the completing edge frees the slot, so the new word is accepted
  // in the same cycle and data_valid never drops between back-to-back words.
  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (word_done) begin
      if (!data_valid || data_ack) begin
        data_out   <= word;
        data_valid <= 1'b1;
      end else begin
        overrun    <= 1'b1;
      end
    end else if (data_ack && data_valid) begin
      data_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_reader.sv
// LSB-first serial-in, parallel-out receiver: bit counter, shift register and
// input FSM, with completed words handed to rx_hold_reg.
module serial_reader
  import serial_reader_pkg::*;
#(
  parameter int width  = RW_WIDTH,
  parameter int cwidth = RW_CWIDTH
) (
  input  logic             sclk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             mosi,
  input  logic             restart,
  input  logic             data_ack,
  output logic [width-1:0] data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             overrun,
  output rd_state_e        fsm_state
);

  localparam logic [cwidth-1:0] last_index = cwidth'(width - 1);

  rd_state_e         state, state_next;
  logic [cwidth-1:0] index, index_next;
  logic [width-1:0]  shift, shift_next;
  logic [width-1:0]  word;
  logic              word_done;

  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RD_IDLE;
      index <= '0;
      shift <= '0;
    end else begin
      state <= state_next;
      index <= index_next;
      shift <= shift_next;
    end
  end

  // restart outranks both a normal sample and a completing sample.
  always_comb begin
    state_next = state;
    index_next = index;
    shift_next = shift;
    word_done  = 1'b0;
    word       = {mosi, shift[width-2:0]};
    if (restart) begin
      state_next = RD_IDLE;
      index_next = '0;
    end else if (enable) begin
      case (state)
        RD_IDLE: begin
          shift_next[0] = mosi;
          index_next    = cwidth'(1);
          state_next    = RD_SHIFT;
        end
        RD_SHIFT: begin
          shift_next[index] = mosi;
          index_next        = index + cwidth'(1);
          if (index == last_index) begin
            word_done  = 1'b1;
            state_next = RD_IDLE;
          end
        end
        default: state_next = RD_IDLE;
      endcase
    end
  end

  assign busy      = (state == RD_SHIFT);
  assign fsm_state = state;

  rx_hold_reg #(.width(width)) u_hold (
    .sclk       (sclk),
    .reset_n    (reset_n),
    .word       (word),
    .word_done  (word_done),
    .data_ack   (data_ack),
    .data_out   (data_out),
    .data_valid (data_valid),
    .overrun    (overrun)
  );

endmodule

// File: tb/tb_serial_reader.sv
// Directed bench for serial_reader: words pushed to a scoreboard queue as they
// are sent, a negedge monitor pops whenever a new word is presented.
module tb_serial_reader;
  import serial_reader_pkg::*;

  localparam int W = 64;

  logic         sclk = 1'b0;
  logic         reset_n;
  logic         enable;
  logic         mosi;
  logic         restart;
  logic         data_ack;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         busy;
  logic         overrun;
  rd_state_e    fsm_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  serial_reader #(.width(W), .cwidth(6)) dut (
    .sclk       (sclk),
    .reset_n    (reset_n),
    .enable     (enable),
    .mosi       (mosi),
    .restart    (restart),
    .data_ack   (data_ack),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .overrun    (overrun),
    .fsm_state  (fsm_state)
  );

  // clock / reset
  always #5 sclk = ~sclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the active edge
  task automatic send_bits(input logic [W-1:0] w, input int lo, input int hi,
                           input int gap, input bit ack_last);
    for (int i = lo; i <= hi; i++) begin
      enable   = 1'b1;
      mosi     = w[i];
      data_ack = ack_last && (i == hi);
      @(posedge sclk); #1;
      enable   = 1'b0;
      data_ack = 1'b0;
      if (gap > 0 && ((i + 1) % 8 == 0) && i != W - 1)
        repeat (gap) begin @(posedge sclk); #1; end
    end
  endtask

  task automatic consume();
    data_ack = 1'b1;
    @(posedge sclk); #1;
    data_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge sclk); #1; end
  endtask

  // scoreboard monitor: a word is newly presented when valid rises, or when
  // valid stays high across an edge on which the previous word was acked.
  logic prev_valid = 1'b0;
  logic ack_pend   = 1'b0;
  always @(negedge sclk) begin
    if (!reset_n) begin
      prev_valid = 1'b0;
      ack_pend   = 1'b0;
    end else begin
      if (data_valid && (!prev_valid || ack_pend)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got word %h, required no word", data_out);
        end else begin
          check("sb_word", data_out, exp_q.pop_front());
        end
      end
      prev_valid = data_valid;
      ack_pend   = data_ack && data_valid;
    end
  end

  logic [W-1:0] junk;

  initial begin
    reset_n  = 1'b0;
    enable   = 1'b0;
    mosi     = 1'b0;
    restart  = 1'b0;
    data_ack = 1'b0;
    #12;
    check("rst_data_out", data_out, '0);
    check("rst_valid", W'(data_valid), '0);
    check("rst_busy", W'(busy), '0);
    check("rst_overrun", W'(overrun), '0);
    check("rst_state", W'(fsm_state), W'(RD_IDLE));
    @(posedge sclk); #1;
    reset_n = 1'b1;
    idle(2);

    // loopback word, plain
    exp_q.push_back(64'h0123_4567_89AB_CDEF);
    send_bits(64'h0123_4567_89AB_CDEF, 0, 31, 0, 0);
    check("mid_busy", W'(busy), 1);
    check("mid_state", W'(fsm_state), W'(RD_SHIFT));
    send_bits(64'h0123_4567_89AB_CDEF, 32, 63, 0, 0);
    check("lb_valid", W'(data_valid), 1);
    check("lb_busy", W'(busy), 0);
    check("lb_overrun", W'(overrun), 0);
    check("lb_data", data_out, 64'h0123_4567_89AB_CDEF);
    consume();
    check("ack_clears_valid", W'(data_valid), 0);

    // same word with enable gaps
    exp_q.push_back(64'h0123_4567_89AB_CDEF);
    send_bits(64'h0123_4567_89AB_CDEF, 0, 62, 3, 0);
    check("gap_valid_before_last", W'(data_valid), 0);
    check("gap_busy_before_last", W'(busy), 1);
    send_bits(64'h0123_4567_89AB_CDEF, 63, 63, 0, 0);
    check("gap_valid", W'(data_valid), 1);
    check("gap_data", data_out, 64'h0123_4567_89AB_CDEF);
    consume();

    // overrun: second word dropped while first is held
    exp_q.push_back(64'hAAAA_AAAA_AAAA_AAAA);
    send_bits(64'hAAAA_AAAA_AAAA_AAAA, 0, 63, 0, 0);
    check("ovr_none_yet", W'(overrun), 0);
    send_bits(64'h5555_5555_5555_5555, 0, 63, 0, 0);
    check("ovr_set", W'(overrun), 1);
    check("ovr_data_kept", data_out, 64'hAAAA_AAAA_AAAA_AAAA);
    idle(5);
    check("ovr_sticky", W'(overrun), 1);
    consume();
    check("ovr_after_ack_valid", W'(data_valid), 0);
    check("ovr_after_ack_data", data_out, 64'hAAAA_AAAA_AAAA_AAAA);
    check("ovr_after_ack_sticky", W'(overrun), 1);
    data_ack = 1'b1;
    idle(1);
    data_ack = 1'b0;
    check("ack_when_empty", W'(data_valid), 0);

    // only reset clears overrun
    #2 reset_n = 1'b0;
    #1;
    check("rst2_overrun", W'(overrun), 0);
    @(posedge sclk); #1;
    reset_n = 1'b1;
    idle(1);

    // back-to-back with ack on the completing edge
    exp_q.push_back(64'hAAAA_AAAA_AAAA_AAAA);
    send_bits(64'hAAAA_AAAA_AAAA_AAAA, 0, 63, 0, 0);
    exp_q.push_back(64'h5555_5555_5555_5555);
    send_bits(64'h5555_5555_5555_5555, 0, 63, 0, 1);
    check("b2b_valid", W'(data_valid), 1);
    check("b2b_data", data_out, 64'h5555_5555_5555_5555);
    check("b2b_overrun", W'(overrun), 0);
    consume();

    // restart mid-word
    junk = 64'h000F_0000_000A_BCDE;
    send_bits(junk, 0, 19, 0, 0);
    restart = 1'b1; enable = 1'b1; mosi = 1'b1;
    @(posedge sclk); #1;
    restart = 1'b0; enable = 1'b0;
    check("restart_busy", W'(busy), 0);
    check("restart_valid", W'(data_valid), 0);
    exp_q.push_back(64'hDEAD_BEEF_0000_FFFF);
    send_bits(64'hDEAD_BEEF_0000_FFFF, 0, 63, 0, 0);
    check("restart_data", data_out, 64'hDEAD_BEEF_0000_FFFF);
    consume();

    // restart on what would be the completing edge: no word produced
    send_bits(64'h1234_5678_9ABC_DEF0, 0, 62, 0, 0);
    restart = 1'b1; enable = 1'b1; mosi = 1'b0;
    @(posedge sclk); #1;
    restart = 1'b0; enable = 1'b0;
    check("restart_vs_done_valid", W'(data_valid), 0);
    check("restart_vs_done_busy", W'(busy), 0);

    // reset mid-word with a word already held
    exp_q.push_back(64'hCAFE_F00D_1357_9BDF);
    send_bits(64'hCAFE_F00D_1357_9BDF, 0, 63, 0, 0);
    send_bits(64'hFFFF_FFFF_FFFF_FFFF, 0, 29, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    check("rstmid_data", data_out, '0);
    check("rstmid_valid", W'(data_valid), 0);
    check("rstmid_busy", W'(busy), 0);
    @(posedge sclk); #1;
    reset_n = 1'b1;
    idle(1);
    exp_q.push_back(64'h0F0F_1E1E_2D2D_3C3C);
    send_bits(64'h0F0F_1E1E_2D2D_3C3C, 0, 63, 0, 0);
    check("rstmid_clean_data", data_out, 64'h0F0F_1E1E_2D2D_3C3C);
    check("rstmid_clean_overrun", W'(overrun), 0);
    consume();

    idle(3);
    check("sb_queue_empty", W'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
